instr_reg_ctrl: RTL and testbench

Write/readback controller for the 32-entry instruction register. Two requesters share the register's single write port through round-robin arbitration. The block auto-generates write_pointer and tracks occupancy. On command it sequences read_pointer across all loaded entries so a checker can collect the stored instruction words in order.

---
 rtl/instr_reg_ctrl_if.sv | 31 +++
 rtl/instr_reg_ctrl.sv | 148 ++++++++++++++
 tb/tb_instr_reg_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_reg_ctrl_if.sv
// Request interface between the two instruction requesters and instr_reg_ctrl.
//
// Handshake: req[i] is a level request (a "valid") that stays high with its
// opcode/operands stable until gnt[i] is seen. gnt[i] is the "ready"; the
// instruction transfers in the cycle where req[i] && gnt[i] are both high.
// The requester drops req[i] or changes its payload only after that cycle.
// rej is high together with gnt when the accepted instruction is discarded.
interface instr_reg_ctrl_if #(
    parameter int OP_W  = 32,
    parameter int OPC_W = 4
);
    logic [1:0]             req;
    logic [OPC_W-1:0]       req_opcode0;
    logic [OPC_W-1:0]       req_opcode1;
    logic signed [OP_W-1:0] req_a0;
    logic signed [OP_W-1:0] req_a1;
    logic signed [OP_W-1:0] req_b0;
    logic signed [OP_W-1:0] req_b1;
    logic [1:0]             gnt;
    logic                   rej;

    modport master (
        output req, req_opcode0, req_opcode1, req_a0, req_a1, req_b0, req_b1,
        input  gnt, rej
    );

    modport slave (
        input  req, req_opcode0, req_opcode1, req_a0, req_a1, req_b0, req_b1,
        output gnt, rej
    );
endinterface

// File: rtl/instr_reg_ctrl.sv
// Write/readback controller for the instruction register: round-robin
// arbitration of two requesters onto one write port, write pointer and
// occupancy tracking, and an in-order readback sweep of the loaded entries.
// busy reflects the FSM state (high in READBACK).
module instr_reg_ctrl #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 32,
    parameter int OPC_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_reg_ctrl_if.slave        bus,
    input  logic                   clear,
    input  logic                   rb_start,
    output logic                   load_en,
    output logic [OPC_W-1:0]       opcode,
    output logic signed [OP_W-1:0] operand_a,
    output logic signed [OP_W-1:0] operand_b,
    output logic [ADDR_W-1:0]      write_pointer,
    output logic [ADDR_W-1:0]      read_pointer,
    output logic                   rb_valid,
    output logic                   rb_done,
    output logic [ADDR_W:0]        count,
    output logic                   full,
    output logic                   busy
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_READBACK = 1'b1
    } state_t;

    localparam logic [OPC_W-1:0] OPC_DIV = OPC_W'(6);
    localparam logic [OPC_W-1:0] OPC_MOD = OPC_W'(7);
    localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  ONE_C   = (ADDR_W+1)'(1);

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDR_W-1:0]      wr_ptr_q;
    logic                   pref_q;     // requester that wins a tie

    logic                   accept;
    logic                   win;
    logic [OPC_W-1:0]       sel_opc;
    logic signed [OP_W-1:0] sel_a;
    logic signed [OP_W-1:0] sel_b;
    logic                   reject;
    logic                   load_fire;
    logic                   last_entry;
    logic                   rb_valid_d;
    logic                   rb_done_d;
    logic [ADDR_W-1:0]      rd_ptr_d;

    assign full       = (count == DEPTH_C);
    assign busy       = (state_q == S_READBACK);
    assign last_entry = ({1'b0, read_pointer} == (count - ONE_C));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state: clear wins over rb_start; an empty register never enters READBACK.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (rb_start && !clear && (count != '0)) state_d = S_READBACK;
            S_READBACK: if (last_entry) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs: arbitration, reject detection and next readback strobes.
    always_comb begin
        accept     = (state_q == S_IDLE) && !full && !clear && !rb_start && (bus.req != 2'b00);
        win        = (bus.req == 2'b11) ? pref_q : bus.req[1];
        sel_opc    = win ? bus.req_opcode1 : bus.req_opcode0;
        sel_a      = win ? bus.req_a1      : bus.req_a0;
        sel_b      = win ? bus.req_b1      : bus.req_b0;
        reject     = accept && ((sel_opc == OPC_DIV) || (sel_opc == OPC_MOD)) && (sel_b == '0);
        load_fire  = accept && !reject;
        bus.gnt    = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
        bus.rej    = reject;
        rb_valid_d = 1'b0;
        rb_done_d  = 1'b0;
        rd_ptr_d   = read_pointer;
        case (state_q)
            S_IDLE: begin
                if (rb_start && !clear) begin
                    if (count != '0) begin
                        rb_valid_d = 1'b1;
                        rd_ptr_d   = '0;
                    end else begin
                        rb_done_d  = 1'b1;
                    end
                end
            end
            S_READBACK: begin
                if (last_entry) begin
                    rb_done_d  = 1'b1;
                end else begin
                    rb_valid_d = 1'b1;
                    rd_ptr_d   = read_pointer + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath: register-port outputs, pointers, occupancy and arbitration priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_en       <= 1'b0;
            opcode        <= '0;
            operand_a     <= '0;
            operand_b     <= '0;
            write_pointer <= '0;
            read_pointer  <= '0;
            rb_valid      <= 1'b0;
            rb_done       <= 1'b0;
            count         <= '0;
            wr_ptr_q      <= '0;
            pref_q        <= 1'b0;
        end else begin
            load_en      <= load_fire;
            rb_valid     <= rb_valid_d;
            rb_done      <= rb_done_d;
            read_pointer <= rd_ptr_d;
            // Rejected grants still rotate priority.
            if (accept) pref_q <= ~win;
            if (load_fire) begin
                opcode        <= sel_opc;
                operand_a     <= sel_a;
                operand_b     <= sel_b;
                write_pointer <= wr_ptr_q;
                wr_ptr_q      <= wr_ptr_q + 1'b1;
                count         <= count + ONE_C;
            end else if ((state_q == S_IDLE) && clear) begin
                wr_ptr_q <= '0;
                count    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Bench for instr_reg_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the controller.
module tb_instr_reg_ctrl;
    localparam int DEPTH = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               clear;
    logic               rb_start;
    logic               load_en;
    logic [3:0]         opcode;
    logic signed [31:0] operand_a;
    logic signed [31:0] operand_b;
    logic [4:0]         write_pointer;
    logic [4:0]         read_pointer;
    logic               rb_valid;
    logic               rb_done;
    logic [5:0]         count;
    logic               full;
    logic               busy;

    instr_reg_ctrl_if bus ();

    instr_reg_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .clear         (clear),
        .rb_start      (rb_start),
        .load_en       (load_en),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .write_pointer (write_pointer),
        .read_pointer  (read_pointer),
        .rb_valid      (rb_valid),
        .rb_done       (rb_done),
        .count         (count),
        .full          (full),
        .busy          (busy)
    );

    // Clock and reset block.
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state.
    int                 m_count = 0;
    int                 m_wr    = 0;
    int                 m_pref  = 0;
    int                 m_rp    = 0;
    int                 m_wp    = 0;
    logic [3:0]         m_opc   = '0;
    logic signed [31:0] m_a     = '0;
    logic signed [31:0] m_b     = '0;
    // Scoreboard of future readback cycles: an index, or DEPTH for the done cycle.
    logic [5:0]         exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_quiet();
        reset    = 1'b0;
        clear    = 1'b0;
        rb_start = 1'b0;
        bus.req  = 2'b00;
    endtask

    task automatic drive_req(input logic [1:0] r, input logic [3:0] o0, input int a0, input int b0,
                             input logic [3:0] o1, input int a1, input int b1);
        bus.req         = r;
        bus.req_opcode0 = o0;
        bus.req_a0      = a0;
        bus.req_b0      = b0;
        bus.req_opcode1 = o1;
        bus.req_a1      = a1;
        bus.req_b1      = b1;
    endtask

    task automatic rand_payload();
        bus.req_opcode0 = 4'($urandom_range(0, 15));
        bus.req_opcode1 = 4'($urandom_range(0, 15));
        bus.req_a0      = $urandom;
        bus.req_a1      = $urandom;
        bus.req_b0      = ($urandom_range(0, 3) == 0) ? 32'sd0 : $urandom;
        bus.req_b1      = ($urandom_range(0, 3) == 0) ? 32'sd0 : $urandom;
    endtask

    // One clock: check the combinational grant, advance the model, check registered outputs.
    task automatic step();
        logic [1:0]         e_gnt;
        logic               e_rej;
        logic               e_load;
        logic               e_valid;
        logic               e_done;
        logic               acc;
        logic               idle;
        int                 w;
        logic [3:0]         opc;
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic [5:0]         nxt;

        @(negedge clk);
        idle    = (exp_q.size() == 0);
        e_gnt   = 2'b00;
        e_rej   = 1'b0;
        e_load  = 1'b0;
        e_valid = 1'b0;
        e_done  = 1'b0;
        acc     = idle && (m_count < DEPTH) && !clear && !rb_start && (bus.req != 2'b00);
        w       = (bus.req == 2'b11) ? m_pref : (bus.req[1] ? 1 : 0);
        opc     = (w == 1) ? bus.req_opcode1 : bus.req_opcode0;
        a       = (w == 1) ? bus.req_a1 : bus.req_a0;
        b       = (w == 1) ? bus.req_b1 : bus.req_b0;
        if (acc) begin
            e_gnt = (w == 1) ? 2'b10 : 2'b01;
            e_rej = ((opc == 4'd6) || (opc == 4'd7)) && (b == 0);
        end
        chk("gnt", bus.gnt, e_gnt);
        chk("rej", bus.rej, e_rej);

        if (reset) begin
            m_count = 0; m_wr = 0; m_pref = 0; m_rp = 0; m_wp = 0;
            m_opc = '0; m_a = '0; m_b = '0;
            exp_q.delete();
        end else if (!idle) begin
            nxt = exp_q.pop_front();
            if (nxt == 6'(DEPTH)) e_done = 1'b1;
            else begin
                e_valid = 1'b1;
                m_rp    = int'(nxt);
            end
        end else if (clear) begin
            m_count = 0;
            m_wr    = 0;
        end else if (rb_start) begin
            if (m_count == 0) e_done = 1'b1;
            else begin
                e_valid = 1'b1;
                m_rp    = 0;
                for (int i = 1; i < m_count; i++) exp_q.push_back(6'(i));
                exp_q.push_back(6'(DEPTH));
            end
        end else if (acc) begin
            m_pref = 1 - w;
            if (!e_rej) begin
                e_load  = 1'b1;
                m_opc   = opc;
                m_a     = a;
                m_b     = b;
                m_wp    = m_wr;
                m_wr    = (m_wr + 1) % DEPTH;
                m_count = m_count + 1;
            end
        end

        @(posedge clk);
        #1;
        chk("load_en", load_en, e_load);
        chk("opcode", opcode, m_opc);
        chk("operand_a", operand_a, m_a);
        chk("operand_b", operand_b, m_b);
        chk("write_pointer", write_pointer, m_wp);
        chk("count", count, m_count);
        chk("full", full, m_count == DEPTH);
        chk("busy", busy, exp_q.size() != 0);
        chk("rb_valid", rb_valid, e_valid);
        chk("rb_done", rb_done, e_done);
        chk("read_pointer", read_pointer, m_rp);
    endtask

    task automatic fill_to_full();
        for (int i = 0; i < 400 && m_count < DEPTH; i++) begin
            bus.req = 2'($urandom_range(0, 3));
            rand_payload();
            step();
        end
        set_quiet();
        chk("full_after_fill", full, 1'b1);
    endtask

    initial begin
        set_quiet();
        drive_req(2'b00, 4'd0, 0, 0, 4'd0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step();                       // reset state checks
        set_quiet();

        // Single ADD from requester 0.
        drive_req(2'b01, 4'd3, 5, 3, 4'd0, 0, 0);
        step();
        set_quiet();
        step();

        // Both requesting for four accepts: alternate grants.
        for (int i = 0; i < 4; i++) begin
            drive_req(2'b11, 4'($urandom_range(0, 5)), $urandom, $urandom_range(1, 99),
                      4'($urandom_range(0, 5)), $urandom, $urandom_range(1, 99));
            step();
        end
        set_quiet();
        step();

        // Divide by zero is rejected, a valid divide is loaded.
        drive_req(2'b01, 4'd6, 7, 0, 4'd0, 0, 0);
        step();
        drive_req(2'b01, 4'd6, 7, 2, 4'd0, 0, 0);
        step();
        drive_req(2'b10, 4'd0, 0, 0, 4'd7, 9, 0);
        step();
        set_quiet();
        step();

        // Fill to full, then stall, then clear beats a request.
        fill_to_full();
        bus.req = 2'b11;
        rand_payload();
        repeat (3) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        drive_req(2'b10, 4'd11, 1, 2, 4'd12, 3, 4);
        step();
        set_quiet();
        step();

        // Full-register readback with requests pending throughout.
        fill_to_full();
        rb_start = 1'b1;
        bus.req  = 2'b11;
        step();
        rb_start = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            rb_start = 1'($urandom_range(0, 1));
            clear    = 1'($urandom_range(0, 1));
            step();
        end
        set_quiet();
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Three loads, readback, request held during readback.
        for (int i = 0; i < 3; i++) begin
            drive_req(2'b01, 4'd1, $urandom, $urandom, 4'd0, 0, 0);
            step();
        end
        bus.req  = 2'b11;
        rb_start = 1'b1;
        step();
        rb_start = 1'b0;
        repeat (5) step();
        set_quiet();

        // Reset in the middle of a readback, then readback of an empty register.
        rb_start = 1'b1;
        step();
        rb_start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        rb_start = 1'b1;
        step();
        rb_start = 1'b0;
        repeat (2) step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            clear    = ($urandom_range(0, 29) == 0);
            rb_start = ($urandom_range(0, 19) == 0);
            bus.req  = 2'($urandom_range(0, 3));
            rand_payload();
            step();
        end
        set_quiet();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
